// File: rtl/secuenciador_microprograma.sv
// Microprogram sequencer: next-microaddress selection with an internal micro-call stack.
// Optional sticky stack-fault flag error_pila enabled by macro SECUENCIADOR_ERROR_PILA_EN.
module secuenciador_microprograma #(
  parameter int ADDR_W     = 8,
  parameter int STACK_D    = 4,
  parameter int RESET_ADDR = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     avanza,
  input  logic                     qseleccionada,
  input  logic                     vf,
  input  logic [2:0]               op,
  input  logic [ADDR_W-1:0]        liga,
  input  logic [ADDR_W-1:0]        vector,
  output logic [ADDR_W-1:0]        micro_dir,
  output logic [$clog2(STACK_D):0] sp,
  output logic                     pila_llena,
`ifdef SECUENCIADOR_ERROR_PILA_EN
  output logic                     pila_vacia,
  output logic                     error_pila
`else
  output logic                     pila_vacia
`endif
);

  localparam int SP_W  = $clog2(STACK_D) + 1;
  localparam int IDX_W = $clog2(STACK_D);
  localparam logic [ADDR_W-1:0] DIR_REINICIO = ADDR_W'(RESET_ADDR);

  typedef enum logic [2:0] {
    CONT      = 3'b000,
    SALTO_C   = 3'b001,
    SALTO     = 3'b010,
    LLAMADA_C = 3'b011,
    RETORNO   = 3'b100,
    MAPEO     = 3'b101,
    RETORNO_C = 3'b110,
    REINICIO  = 3'b111
  } op_t;

  op_t               op_e;
  logic              cond;
  logic [ADDR_W-1:0] inc;
  logic [ADDR_W-1:0] nxt_dir;
  logic              push;
  logic              pop;
  logic              clr;
  logic              ret;
  logic [IDX_W-1:0]  idx_push;
  logic [IDX_W-1:0]  idx_pop;
  logic [ADDR_W-1:0] pila [STACK_D];

  assign op_e       = op_t'(op);
  assign cond       = (qseleccionada == vf);
  assign inc        = micro_dir + 1'b1;
  assign idx_push   = sp[IDX_W-1:0];
  assign idx_pop    = sp[IDX_W-1:0] - 1'b1;
  assign pila_llena = (sp == SP_W'(STACK_D));
  assign pila_vacia = (sp == '0);

  always_comb begin
    nxt_dir = inc;
    push    = 1'b0;
    pop     = 1'b0;
    clr     = 1'b0;
    ret     = 1'b0;
    unique case (op_e)
      CONT:      ;
      SALTO_C:   if (cond) nxt_dir = liga;
      SALTO:     nxt_dir = liga;
      LLAMADA_C: if (cond && !pila_llena) begin
                   push    = 1'b1;
                   nxt_dir = liga;
                 end
      RETORNO:   ret = 1'b1;
      MAPEO:     nxt_dir = vector;
      RETORNO_C: ret = cond;
      REINICIO:  begin
                   nxt_dir = DIR_REINICIO;
                   clr     = 1'b1;
                 end
    endcase
    // Returning on an empty stack restarts the microprogram instead of popping.
    if (ret) begin
      if (!pila_vacia) begin
        pop     = 1'b1;
        nxt_dir = pila[idx_pop];
      end else begin
        nxt_dir = DIR_REINICIO;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      micro_dir <= DIR_REINICIO;
      sp        <= '0;
      for (int unsigned i = 0; i < STACK_D; i++) pila[i] <= '0;
    end else if (avanza) begin
      micro_dir <= nxt_dir;
      if (clr) begin
        sp <= '0;
      end else if (push) begin
        pila[idx_push] <= inc;
        sp             <= sp + 1'b1;
      end else if (pop) begin
        sp <= sp - 1'b1;
      end
    end
  end

`ifdef SECUENCIADOR_ERROR_PILA_EN
  logic fallo;

  assign fallo = (op_e == LLAMADA_C && cond && pila_llena) || (ret && pila_vacia);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      error_pila <= 1'b0;
    end else if (avanza) begin
      if (clr)        error_pila <= 1'b0;
      else if (fallo) error_pila <= 1'b1;
    end
  end
`endif

endmodule

// File: doc/secuenciador_microprograma.md
Name: secuenciador_microprograma

Overview:
- Microprogram sequencer sitting directly downstream of the condition-select multiplexor in the microprogrammed control unit.
- Consumes the selected test bit (qseleccionada) plus the current microinstruction's sequencing fields.
- Produces the next microaddress into the control store each cycle.
- Keeps an internal micro-call stack for microsubroutines.

Parameters:
ADDR_W, 8, microaddress width in bits
STACK_D, 4, micro-call stack depth in entries (power of two, >= 2)
RESET_ADDR, 0, microaddress loaded on reset, REINICIO, and return-on-empty

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-high reset
avanza  in  1  advance enable; 0 = hold all state
qseleccionada  in  1  selected condition bit from the condition multiplexor
vf  in  1  condition polarity; condition true when qseleccionada == vf
op  in  3  sequencing operation of current microinstruction
liga  in  ADDR_W  branch/call target field of microinstruction
vector  in  ADDR_W  opcode-map target (from instruction decode ROM)
micro_dir  out  ADDR_W  current microaddress (registered) to control store
sp  out  $clog2(STACK_D)+1  stack occupancy, 0..STACK_D
pila_llena  out  1  sp == STACK_D (combinational from sp)
pila_vacia  out  1  sp == 0 (combinational from sp)

Behaviour:
- Reset:
  - Asynchronous on reset high, regardless of clk or avanza.
  - micro_dir=RESET_ADDR, sp=0, all stack entries=0.
  - pila_vacia=1, pila_llena=0.
  - Applies immediately even mid-operation; no pending push/pop survives.
- Definitions:
  - cond = (qseleccionada == vf), sampled at the same rising edge that uses it.
  - inc = micro_dir+1, computed modulo 2^ADDR_W (all-ones wraps to 0, no flag).
- Latency: one cycle. Inputs sampled at edge N; new micro_dir visible after edge N.
- avanza=0: micro_dir, sp and stack are unchanged; op is ignored.
- op codes, applied at an edge with avanza=1:
  - 000 CONT: micro_dir <- inc.
  - 001 SALTO_C: micro_dir <- cond ? liga : inc.
  - 010 SALTO: micro_dir <- liga (cond ignored).
  - 011 LLAMADA_C:
    - If cond and not full: push inc; sp+1; micro_dir <- liga.
    - If cond and full: treated as CONT (no push, no branch).
    - If not cond: CONT.
  - 100 RETORNO:
    - If not empty: micro_dir <- top of stack; sp-1.
    - If empty: micro_dir <- RESET_ADDR; sp stays 0.
  - 101 MAPEO: micro_dir <- vector.
  - 110 RETORNO_C: cond ? RETORNO behaviour : CONT.
  - 111 REINICIO: micro_dir <- RESET_ADDR; sp <- 0 (stack contents need not be cleared).
- Stack:
  - LIFO. Entry index = sp at push; popped value = entry sp-1.
  - Only one push or one pop per cycle; no op does both.
  - Popped entries are not cleared.
- All outputs are registered or a pure decode of registers; no combinational path from inputs to outputs.

Optional Feature:
- Macro SECUENCIADOR_ERROR_PILA_EN.
- When defined:
  - Adds output error_pila (1 bit, reset 0).
  - Sticky: set at the edge where LLAMADA_C with cond hits a full stack (overflow), or where a taken RETORNO/RETORNO_C hits an empty stack (underflow).
  - Cleared only by reset or REINICIO; REINICIO wins over a same-cycle set.
  - Sequencing behaviour is identical to the undefined case.
- When undefined: port absent, no extra logic.

Test Plan:
1. Reset then 3 x CONT with avanza=1 -> micro_dir 0,1,2,3; sp=0; pila_vacia=1.
2. micro_dir=0x10, SALTO_C liga=0x40, vf=1: qseleccionada=0 -> 0x11; next cycle qseleccionada=1 -> 0x40.
3. micro_dir=0x20, LLAMADA_C cond true, liga=0x80 -> micro_dir=0x80, sp=1; then RETORNO -> micro_dir=0x21, sp=0.
4. STACK_D=4: five taken LLAMADA_C from 0x00 to liga=0x50 -> sp 1..4 with pila_llena=1 after the 4th; 5th gives micro_dir=0x51, sp=4, error_pila=1 (macro on); then 4 RETORNO unwind in LIFO order; then a 5th RETORNO -> micro_dir=RESET_ADDR, sp=0.
5. micro_dir=0xFF (ADDR_W=8), CONT -> 0x00; MAPEO vector=0x33 with avanza=0 -> micro_dir held; avanza=1 -> 0x33.
6. sp=2 at micro_dir=0x44, assert reset asynchronously between edges -> micro_dir=RESET_ADDR and sp=0 immediately, before the next edge; after release, CONT -> RESET_ADDR+1.
